mdu: RTL and testbench

Multiply/divide unit for the five-stage pipeline, placed in the E stage beside the ALU and driven by the same E-stage operands. It owns the HI/LO registers, runs MULT/MULTU/DIV/DIVU as fixed-latency multi-cycle operations, services MTHI/MTLO/MFHI/MFLO, and exports `busy` so the stall unit can hold MD-class instructions in D.

---
 rtl/mdu_pkg.sv | 30 +++
 rtl/mdu_if.sv | 14 +
 rtl/mdu.sv | 156 +++++++++++++++
 tb/tb_mdu.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: operation encodings,
// FSM state type and a small elaboration-time helper.
package mdu_pkg;

    typedef enum logic [3:0] {
        MDU_NONE  = 4'd0,
        MDU_MULT  = 4'd1,
        MDU_MULTU = 4'd2,
        MDU_DIV   = 4'd3,
        MDU_DIVU  = 4'd4,
        MDU_MFHI  = 4'd5,
        MDU_MFLO  = 4'd6,
        MDU_MTHI  = 4'd7,
        MDU_MTLO  = 4'd8,
        MDU_MADD  = 4'd9,
        MDU_MADDU = 4'd10,
        MDU_MSUB  = 4'd11,
        MDU_MSUBU = 4'd12
    } mdu_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } mdu_state_e;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/mdu_if.sv
// E-stage operand/control bundle between the pipeline and the MDU.
interface mdu_if;
    logic        start;
    logic [3:0]  MDU_op;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic [31:0] MDU_out;

    modport master (output start, output MDU_op, output A, output B,
                    input busy, input MDU_out);
    modport slave  (input start, input MDU_op, input A, input B,
                    output busy, output MDU_out);
endinterface

// File: rtl/mdu.sv
// Multiply/divide unit owning HI/LO; fixed-latency MULT/DIV with busy for stalls.
// Optional MADD/MADDU/MSUB/MSUBU accumulate ops are enabled by defining MDU_MADD_EN.
module mdu
    import mdu_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input logic   clk,
    input logic   reset,
    mdu_if.slave  bus
);

    localparam int MAX_CYCLES = max_int(MULT_CYCLES, DIV_CYCLES);
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);
    localparam logic [CNT_W-1:0] MULT_CNT = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_CNT  = CNT_W'(DIV_CYCLES);

    mdu_state_e       state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [31:0]      hi_reg, hi_next;
    logic [31:0]      lo_reg, lo_next;
    logic [31:0]      res_hi_reg, res_hi_next;
    logic [31:0]      res_lo_reg, res_lo_next;

    logic [63:0] prod_s, prod_u;
    logic [31:0] abs_a, abs_b, quot_mag, rem_mag, quot_s, rem_s, quot_u, rem_u;
    logic        b_zero;

    assign prod_s = {{32{bus.A[31]}}, bus.A} * {{32{bus.B[31]}}, bus.B};
    assign prod_u = {32'b0, bus.A} * {32'b0, bus.B};

    // Signed divide is done on magnitudes so INT_MIN / -1 wraps to INT_MIN
    // instead of relying on tool behaviour for an overflowing signed divide.
    assign b_zero   = (bus.B == 32'd0);
    assign abs_a    = bus.A[31] ? -bus.A : bus.A;
    assign abs_b    = bus.B[31] ? -bus.B : bus.B;
    assign quot_mag = abs_a / abs_b;
    assign rem_mag  = abs_a % abs_b;
    assign quot_s   = (bus.A[31] ^ bus.B[31]) ? -quot_mag : quot_mag;
    assign rem_s    = bus.A[31] ? -rem_mag : rem_mag;
    assign quot_u   = bus.A / bus.B;
    assign rem_u    = bus.A % bus.B;

`ifdef MDU_MADD_EN
    logic [63:0] acc;
    assign acc = {hi_reg, lo_reg};
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg  <= ST_IDLE;
            cnt_reg    <= '0;
            hi_reg     <= '0;
            lo_reg     <= '0;
            res_hi_reg <= '0;
            res_lo_reg <= '0;
        end else begin
            state_reg  <= state_next;
            cnt_reg    <= cnt_next;
            hi_reg     <= hi_next;
            lo_reg     <= lo_next;
            res_hi_reg <= res_hi_next;
            res_lo_reg <= res_lo_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        hi_next     = hi_reg;
        lo_next     = lo_reg;
        res_hi_next = res_hi_reg;
        res_lo_next = res_lo_reg;

        case (state_reg)
            ST_IDLE: begin
                if (bus.start) begin
                    case (mdu_op_e'(bus.MDU_op))
                        MDU_MULT: begin
                            {res_hi_next, res_lo_next} = prod_s;
                            cnt_next   = MULT_CNT;
                            state_next = ST_RUN;
                        end
                        MDU_MULTU: begin
                            {res_hi_next, res_lo_next} = prod_u;
                            cnt_next   = MULT_CNT;
                            state_next = ST_RUN;
                        end
                        // Divide by zero still takes the full latency but
                        // re-commits the current HI/LO, leaving them unchanged.
                        MDU_DIV: begin
                            {res_hi_next, res_lo_next} = b_zero ? {hi_reg, lo_reg}
                                                                : {rem_s, quot_s};
                            cnt_next   = DIV_CNT;
                            state_next = ST_RUN;
                        end
                        MDU_DIVU: begin
                            {res_hi_next, res_lo_next} = b_zero ? {hi_reg, lo_reg}
                                                                : {rem_u, quot_u};
                            cnt_next   = DIV_CNT;
                            state_next = ST_RUN;
                        end
                        MDU_MTHI: hi_next = bus.A;
                        MDU_MTLO: lo_next = bus.A;
`ifdef MDU_MADD_EN
                        MDU_MADD: begin
                            {res_hi_next, res_lo_next} = acc + prod_s;
                            cnt_next   = MULT_CNT;
                            state_next = ST_RUN;
                        end
                        MDU_MADDU: begin
                            {res_hi_next, res_lo_next} = acc + prod_u;
                            cnt_next   = MULT_CNT;
                            state_next = ST_RUN;
                        end
                        MDU_MSUB: begin
                            {res_hi_next, res_lo_next} = acc - prod_s;
                            cnt_next   = MULT_CNT;
                            state_next = ST_RUN;
                        end
                        MDU_MSUBU: begin
                            {res_hi_next, res_lo_next} = acc - prod_u;
                            cnt_next   = MULT_CNT;
                            state_next = ST_RUN;
                        end
`endif
                        default: ;
                    endcase
                end
            end
            ST_RUN: begin
                cnt_next = cnt_reg - 1'b1;
                if (cnt_reg <= CNT_W'(1)) begin
                    cnt_next   = '0;
                    hi_next    = res_hi_reg;
                    lo_next    = res_lo_reg;
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign bus.busy = (state_reg == ST_RUN);

    always_comb begin
        bus.MDU_out = 32'd0;
        case (mdu_op_e'(bus.MDU_op))
            MDU_MFHI: bus.MDU_out = hi_reg;
            MDU_MFLO: bus.MDU_out = lo_reg;
            default:  bus.MDU_out = 32'd0;
        endcase
    end

endmodule

// File: tb/tb_mdu.sv
// Scoreboard testbench for mdu: expected HI/LO/latency queued at issue,
// popped and compared when the operation retires.
module tb_mdu;
    import mdu_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mdu_if bus();

    mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        string       name;
        logic [31:0] hi;
        logic [31:0] lo;
        int          cycles;
    } exp_t;

    exp_t exp_q[$];

    task automatic drive(input mdu_op_e op, input logic [31:0] a, input logic [31:0] b);
        bus.start  = 1'b1;
        bus.MDU_op = op;
        bus.A      = a;
        bus.B      = b;
        @(posedge clk);
        #1;
        bus.start  = 1'b0;
        bus.MDU_op = MDU_NONE;
        bus.A      = 32'd0;
        bus.B      = 32'd0;
    endtask

    task automatic wait_busy(output int cycles);
        cycles = 0;
        while (bus.busy === 1'b1 && cycles < 200) begin
            @(posedge clk);
            #1;
            cycles++;
        end
    endtask

    task automatic read_hilo(output logic [31:0] hi, output logic [31:0] lo);
        bus.MDU_op = MDU_MFHI;
        #1;
        hi = bus.MDU_out;
        bus.MDU_op = MDU_MFLO;
        #1;
        lo = bus.MDU_out;
        bus.MDU_op = MDU_NONE;
    endtask

    task automatic test_reset;
        logic [31:0] hi, lo;
        exp_t e;
        n_tests++;
        if (bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_busy: got %b want 0", bus.busy);
        end
        read_hilo(hi, lo);
        n_tests++;
        if (hi !== 32'd0 || lo !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_hilo: got %h/%h want 0/0", hi, lo);
        end
        @(posedge clk);
        #1 reset = 1'b0;

        drive(MDU_MTHI, 32'hAAAA5555, 32'd0);
        drive(MDU_MTLO, 32'h5555AAAA, 32'd0);
        exp_q.push_back('{"reset_mid_run", 32'd0, 32'd0, 0});
        drive(MDU_MULT, 32'd3, 32'd4);
        @(posedge clk);
        #3 reset = 1'b1;
        #1;
        n_tests++;
        if (bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_async_busy: got %b want 0", bus.busy);
        end
        @(posedge clk);
        #1 reset = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        read_hilo(hi, lo);
        e = exp_q.pop_front();
        $display("[TB] %s: busy=%b hi=%h lo=%h", e.name, bus.busy, hi, lo);
        n_tests++;
        if (hi !== e.hi || lo !== e.lo || bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL %s: got busy=%b %h/%h want 0 %h/%h", e.name, bus.busy, hi, lo, e.hi, e.lo);
        end
    endtask

    task automatic test_arith;
        mdu_op_e     ops[7];
        logic [31:0] as[7], bs[7];
        logic [63:0] p;
        longint      sa, sb, q, r;
        logic [31:0] hi, lo;
        int          cyc;
        exp_t        e;
        ops = '{MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU, MDU_DIV, MDU_MULT, MDU_DIV};
        as  = '{32'hFFFFFFFE, 32'hFFFFFFFE, 32'hFFFFFFF9, 32'd7, 32'h80000000, $urandom, $urandom};
        bs  = '{32'd3, 32'd3, 32'd2, 32'd0, 32'hFFFFFFFF, $urandom, $urandom_range(1, 50000)};
        exp_q.push_back('{"mult_neg", 32'hFFFFFFFF, 32'hFFFFFFFA, 5});
        exp_q.push_back('{"multu", 32'h00000002, 32'hFFFFFFFA, 5});
        exp_q.push_back('{"div_neg", 32'hFFFFFFFF, 32'hFFFFFFFD, 10});
        exp_q.push_back('{"divu_by_zero", 32'hFFFFFFFF, 32'hFFFFFFFD, 10});
        exp_q.push_back('{"div_overflow", 32'h00000000, 32'h80000000, 10});
        for (int i = 0; i < 7; i++) begin
            if (i == 5) begin
                sa = longint'($signed(as[i]));
                sb = longint'($signed(bs[i]));
                p  = 64'(sa * sb);
                exp_q.push_back('{"mult_rand", p[63:32], p[31:0], 5});
            end else if (i == 6) begin
                sa = longint'($signed(as[i]));
                sb = longint'($signed(bs[i]));
                q  = sa / sb;
                r  = sa % sb;
                exp_q.push_back('{"div_rand", r[31:0], q[31:0], 10});
            end
            drive(ops[i], as[i], bs[i]);
            wait_busy(cyc);
            read_hilo(hi, lo);
            e = exp_q.pop_front();
            $display("[TB] %s A=%h B=%h: cycles=%0d hi=%h lo=%h", e.name, as[i], bs[i], cyc, hi, lo);
            n_tests++;
            if (cyc != e.cycles) begin
                n_fail++;
                $display("FAIL %s_latency: got %0d want %0d", e.name, cyc, e.cycles);
            end
            n_tests++;
            if (hi !== e.hi || lo !== e.lo) begin
                n_fail++;
                $display("FAIL %s: got %h/%h want %h/%h", e.name, hi, lo, e.hi, e.lo);
            end
        end
    endtask

    task automatic test_mt;
        logic [31:0] hi, lo;
        int          cyc;
        exp_t        e;
        exp_q.push_back('{"mtlo_mflo", 32'hCAFEF00D, 32'h12345678, 0});
        drive(MDU_MTHI, 32'hCAFEF00D, 32'd0);
        drive(MDU_MTLO, 32'h12345678, 32'd0);
        read_hilo(hi, lo);
        e = exp_q.pop_front();
        $display("[TB] %s: hi=%h lo=%h", e.name, hi, lo);
        n_tests++;
        if (hi !== e.hi || lo !== e.lo) begin
            n_fail++;
            $display("FAIL %s: got %h/%h want %h/%h", e.name, hi, lo, e.hi, e.lo);
        end

        exp_q.push_back('{"mthi_while_busy", 32'hFFFFFFFF, 32'hFFFFFFFA, 5});
        drive(MDU_MULT, 32'hFFFFFFFE, 32'd3);
        $display("[TB] protocol: start (MTHI) issued while busy, must be ignored");
        drive(MDU_MTHI, 32'hDEADBEEF, 32'd0);
        wait_busy(cyc);
        cyc = cyc + 1;
        read_hilo(hi, lo);
        e = exp_q.pop_front();
        $display("[TB] %s: cycles=%0d hi=%h lo=%h", e.name, cyc, hi, lo);
        n_tests++;
        if (cyc != e.cycles || hi !== e.hi || lo !== e.lo) begin
            n_fail++;
            $display("FAIL %s: got %0d %h/%h want %0d %h/%h", e.name, cyc, hi, lo, e.cycles, e.hi, e.lo);
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] hi, lo;
        int          cyc;
        exp_t        e;
        exp_q.push_back('{"mult_during_div", 32'd2, 32'd14, 10});
        drive(MDU_DIV, 32'd100, 32'd7);
        repeat (2) @(posedge clk);
        #1;
        $display("[TB] protocol: start (MULT) issued while busy, must be ignored");
        drive(MDU_MULT, 32'hFFFFFFFE, 32'd3);
        wait_busy(cyc);
        cyc = cyc + 3;
        read_hilo(hi, lo);
        e = exp_q.pop_front();
        $display("[TB] %s: cycles=%0d hi=%h lo=%h", e.name, cyc, hi, lo);
        n_tests++;
        if (cyc != e.cycles) begin
            n_fail++;
            $display("FAIL %s_latency: got %0d want %0d", e.name, cyc, e.cycles);
        end
        n_tests++;
        if (hi !== e.hi || lo !== e.lo) begin
            n_fail++;
            $display("FAIL %s: got %h/%h want %h/%h", e.name, hi, lo, e.hi, e.lo);
        end
    endtask

`ifdef MDU_MADD_EN
    task automatic test_madd;
        logic [31:0] hi, lo;
        int          cyc;
        exp_t        e;
        drive(MDU_MTHI, 32'd0, 32'd0);
        drive(MDU_MTLO, 32'hFFFFFFFF, 32'd0);
        exp_q.push_back('{"maddu_carry", 32'd1, 32'd0, 5});
        drive(MDU_MADDU, 32'd1, 32'd1);
        wait_busy(cyc);
        read_hilo(hi, lo);
        e = exp_q.pop_front();
        $display("[TB] %s: cycles=%0d hi=%h lo=%h", e.name, cyc, hi, lo);
        n_tests++;
        if (cyc != e.cycles || hi !== e.hi || lo !== e.lo) begin
            n_fail++;
            $display("FAIL %s: got %0d %h/%h want %0d %h/%h", e.name, cyc, hi, lo, e.cycles, e.hi, e.lo);
        end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.start  = 1'b0;
        bus.MDU_op = MDU_NONE;
        bus.A      = 32'd0;
        bus.B      = 32'd0;
        reset      = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        test_reset;
        test_arith;
        test_mt;
        test_back_to_back;
`ifdef MDU_MADD_EN
        test_madd;
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
